quadrature_tuner_mc: RTL and testbench

Parametrised, sample-handshaked quadrature tuner with an integrated phase-continuous NCO. Each accepted complex input sample is multiplied by a complex local oscillator, rounded and saturated. Frequency and direction changes take effect atomically at a sample boundary. The block sits between the ADC front-end decimator and the channel filters, replacing the fixed-width tuner, and adds input/output valid qualification.

---
 rtl/tuner_pkg.sv | 35 +++
 rtl/tuner_sincos.sv | 57 +++++
 rtl/quadrature_tuner_mc.sv | 159 +++++++++++++++
 tb/tb_quadrature_tuner_mc.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/tuner_pkg.sv
// rtl/tuner_pkg.sv - shared constants and helper functions for the quadrature tuner
//   LFSR width/taps/seed for phase dither, pipeline latency, rounding offset,
//   saturation limits and the sine LUT entry generator (elaboration-time only).
package tuner_pkg;

    localparam int          LFSR_W    = 32;
    // Galois taps for x^32 + x^22 + x^2 + x + 1 (right-shifting form)
    localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;
    localparam logic [31:0] LFSR_SEED = 32'hACE1_2468;

    // in_valid at cycle t -> out_valid at cycle t+PIPE_LAT
    localparam int          PIPE_LAT  = 4;

    function automatic longint rnd_offset(input int dw);
        return longint'(1) << (dw - 2);
    endfunction

    function automatic longint sat_max(input int dw);
        return (longint'(1) << (dw - 1)) - 1;
    endfunction

    function automatic longint sat_min(input int dw);
        return -(longint'(1) << (dw - 1));
    endfunction

    // Quarter-wave entry k: round-to-nearest of A*sin(2*pi*k/2^pw), always >= 0
    function automatic int lut_entry(input int k, input int dw, input int pw);
        real amp;
        real ang;
        amp = real'(sat_max(dw));
        ang = 6.283185307179586 * real'(k) / real'(1 << pw);
        return $rtoi(amp * $sin(ang) + 0.5);
    endfunction

endpackage

// File: rtl/tuner_sincos.sv
// rtl/tuner_sincos.sv - quarter-wave sine/cosine generator, 2 registered stages
//   clk      : clock
//   theta    : PW-bit phase, full circle = 2^PW
//   sin_out  : A*sin(theta), valid two cycles after theta
//   cos_out  : A*cos(theta), valid two cycles after theta
module tuner_sincos
    import tuner_pkg::*;
#(
    parameter int DW = 16,
    parameter int PW = 12
) (
    input  logic                 clk,
    input  logic [PW-1:0]        theta,
    output logic signed [DW-1:0] sin_out,
    output logic signed [DW-1:0] cos_out
);

    localparam int AW = PW - 2;
    localparam int NQ = 1 << AW;
    localparam logic signed [DW-1:0] AMP = DW'(sat_max(DW));

    logic [DW-1:0] lut [NQ];

    for (genvar k = 0; k < NQ; k++) begin : g_lut
        localparam int V = lut_entry(k, DW, PW);
        assign lut[k] = V[DW-1:0];
    end

    // Channel 0 is sine; channel 1 is cosine, i.e. sine a quarter turn ahead.
    for (genvar c = 0; c < 2; c++) begin : g_ch
        logic [1:0]           quad;
        logic [AW-1:0]        j;
        logic [AW-1:0]        addr_r;
        logic                 peak_r;
        logic                 neg_r;
        logic signed [DW-1:0] mag;
        logic signed [DW-1:0] lo_r;

        assign quad = theta[PW-1 -: 2] + 2'(c);
        assign j    = theta[AW-1:0];

        // Odd quadrants read the table mirrored (NQ - j); j == 0 there is the
        // peak, which lies one past the end of the quarter table.
        assign mag = peak_r ? AMP : $signed(lut[addr_r]);

        always_ff @(posedge clk) begin
            addr_r <= quad[0] ? (~j + 1'b1) : j;
            peak_r <= quad[0] && (j == '0);
            neg_r  <= quad[1];
            lo_r   <= neg_r ? -mag : mag;
        end
    end

    assign sin_out = g_ch[0].lo_r;
    assign cos_out = g_ch[1].lo_r;

endmodule

// File: rtl/quadrature_tuner_mc.sv
// rtl/quadrature_tuner_mc.sv - sample-handshaked quadrature tuner with phase-continuous NCO
//   clk, reset            : clock, synchronous active-high reset
//   in_valid, in_i, in_q  : input sample strobe and signed complex sample
//   cfg_valid/cfg_ready   : config handshake for cfg_freq (tuning word) and cfg_inv
//   phase_clr             : sample taken with this uses phase 0, acc restarts
//   dither_en             : phase dither enable (only with QUADRATURE_TUNER_DITHER_EN)
//   out_valid, out_i/q    : mixed, rounded, saturated output, 4 cycles after input
//   Optional build macro  : QUADRATURE_TUNER_DITHER_EN
module quadrature_tuner_mc
    import tuner_pkg::*;
#(
    parameter int DW = 16,
    parameter int FW = 32,
    parameter int PW = 12
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    input  logic signed [DW-1:0] in_i,
    input  logic signed [DW-1:0] in_q,
    input  logic                 cfg_valid,
    output logic                 cfg_ready,
    input  logic [FW-1:0]        cfg_freq,
    input  logic                 cfg_inv,
    input  logic                 phase_clr,
    input  logic                 dither_en,
    output logic                 out_valid,
    output logic signed [DW-1:0] out_i,
    output logic signed [DW-1:0] out_q
);

    localparam logic signed [2*DW:0] RND    = (2*DW+1)'(rnd_offset(DW));
    localparam logic signed [2*DW:0] SAT_HI = (2*DW+1)'(sat_max(DW));
    localparam logic signed [2*DW:0] SAT_LO = (2*DW+1)'(sat_min(DW));

    logic [FW-1:0] acc, freq, sh_freq;
    logic          inv, sh_inv, pending;
    logic [FW-1:0] phase_c, phase_d;
    logic          unused_bits;

    assign cfg_ready = !pending;

    // The shadow is only loaded when nothing is pending and only applied when
    // something is, so the two never collide. Applying happens after the
    // current sample's step, so that sample still sees the old freq/inv.
    always_ff @(posedge clk) begin
        if (reset) begin
            acc     <= '0;
            freq    <= '0;
            inv     <= 1'b0;
            sh_freq <= '0;
            sh_inv  <= 1'b0;
            pending <= 1'b0;
        end else begin
            if (cfg_valid && cfg_ready) begin
                sh_freq <= cfg_freq;
                sh_inv  <= cfg_inv;
                pending <= 1'b1;
            end
            if (in_valid) begin
                acc <= (phase_clr ? '0 : acc) + freq;
                if (pending) begin
                    freq    <= sh_freq;
                    inv     <= sh_inv;
                    pending <= 1'b0;
                end
            end
        end
    end

    assign phase_c = phase_clr ? '0 : acc;

`ifdef QUADRATURE_TUNER_DITHER_EN
    logic [LFSR_W-1:0] lfsr;

    always_ff @(posedge clk) begin
        if (reset) begin
            lfsr <= LFSR_SEED;
        end else if (in_valid) begin
            lfsr <= lfsr[0] ? ((lfsr >> 1) ^ LFSR_TAPS) : (lfsr >> 1);
        end
    end

    assign phase_d     = phase_c + (dither_en ? FW'(lfsr[FW-PW-1:0]) : '0);
    assign unused_bits = ^{lfsr[LFSR_W-1:FW-PW], phase_d[FW-PW-1:0]};
`else
    assign phase_d     = phase_c;
    assign unused_bits = ^{dither_en, phase_d[FW-PW-1:0]};
`endif

    logic                 v1, v2, v3;
    logic [PW-1:0]        theta1;
    logic                 inv1, inv2, inv3;
    logic signed [DW-1:0] i1, i2, i3, q1, q2, q3;
    logic signed [DW-1:0] lo_c, lo_s, lo_s_eff;

    always_ff @(posedge clk) begin
        theta1 <= phase_d[FW-1 -: PW];
        inv1   <= inv;
        inv2   <= inv1;
        inv3   <= inv2;
        i1     <= in_i;
        i2     <= i1;
        i3     <= i2;
        q1     <= in_q;
        q2     <= q1;
        q3     <= q2;
    end

    tuner_sincos #(.DW(DW), .PW(PW)) u_sincos (
        .clk     (clk),
        .theta   (theta1),
        .sin_out (lo_s),
        .cos_out (lo_c)
    );

    // Conjugate LO for negative frequency; -A is representable so no overflow.
    assign lo_s_eff = inv3 ? -lo_s : lo_s;

    logic signed [2*DW-1:0] p_ic, p_qs, p_is, p_qc;
    logic signed [2*DW:0]   sum_i, sum_q, scl_i, scl_q;

    assign p_ic  = i3 * lo_c;
    assign p_qs  = q3 * lo_s_eff;
    assign p_is  = i3 * lo_s_eff;
    assign p_qc  = q3 * lo_c;
    assign sum_i = (2*DW+1)'(p_ic) - (2*DW+1)'(p_qs);
    assign sum_q = (2*DW+1)'(p_is) + (2*DW+1)'(p_qc);
    assign scl_i = (sum_i + RND) >>> (DW - 1);
    assign scl_q = (sum_q + RND) >>> (DW - 1);

    function automatic logic signed [DW-1:0] sat(input logic signed [2*DW:0] x);
        if (x > SAT_HI) return SAT_HI[DW-1:0];
        if (x < SAT_LO) return SAT_LO[DW-1:0];
        return x[DW-1:0];
    endfunction

    // Output registers only load on a valid sample so they hold between samples.
    always_ff @(posedge clk) begin
        if (reset) begin
            v1        <= 1'b0;
            v2        <= 1'b0;
            v3        <= 1'b0;
            out_valid <= 1'b0;
            out_i     <= '0;
            out_q     <= '0;
        end else begin
            v1        <= in_valid;
            v2        <= v1;
            v3        <= v2;
            out_valid <= v3;
            if (v3) begin
                out_i <= sat(scl_i);
                out_q <= sat(scl_q);
            end
        end
    end

endmodule

// File: tb/tb_quadrature_tuner_mc.sv
// tb/tb_quadrature_tuner_mc.sv - directed and randomized bench for quadrature_tuner_mc
module tb_quadrature_tuner_mc;
    import tuner_pkg::*;

    logic               clk = 1'b0;
    logic               reset;
    logic               in_valid;
    logic signed [15:0] in_i, in_q;
    logic               cfg_valid;
    logic               cfg_ready;
    logic [31:0]        cfg_freq;
    logic               cfg_inv;
    logic               phase_clr;
    logic               dither_en;
    logic               out_valid;
    logic signed [15:0] out_i, out_q;

    quadrature_tuner_mc #(.DW(16), .FW(32), .PW(12)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_i      (in_i),
        .in_q      (in_q),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_freq  (cfg_freq),
        .cfg_inv   (cfg_inv),
        .phase_clr (phase_clr),
        .dither_en (dither_en),
        .out_valid (out_valid),
        .out_i     (out_i),
        .out_q     (out_q)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [31:0] m_acc, m_freq, m_sh_freq;
    bit          m_inv, m_sh_inv, m_pend;
    bit          pv [PIPE_LAT];
    int          pi [PIPE_LAT];
    int          pq [PIPE_LAT];
    int          last_i, last_q;

    task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Ideal LO value from the full circle, rounded to nearest.
    function automatic int lo_val(input int th, input bit is_cos);
        real ang, v;
        ang = 6.283185307179586 * real'(th) / 4096.0;
        v   = (is_cos ? $cos(ang) : $sin(ang)) * 32767.0;
        if (v >= 0.0) return $rtoi($floor(v + 0.5));
        return -$rtoi($floor(-v + 0.5));
    endfunction

    function automatic int scale_sat(input longint s);
        longint r;
        r = (s + 16384) >>> 15;
        if (r > 32767)  r = 32767;
        if (r < -32768) r = -32768;
        return int'(r);
    endfunction

    task automatic step(input bit v, input int ii, input int qq, input bit clr,
                        input bit cv, input logic [31:0] cf, input bit ci, input bit rst);
        bit          nv;
        int          ni, nq, th, c, s;
        bit          pend_old;
        logic [31:0] ph;
        reset     = rst;
        in_valid  = v;
        in_i      = ii[15:0];
        in_q      = qq[15:0];
        phase_clr = clr;
        cfg_valid = cv;
        cfg_freq  = cf;
        cfg_inv   = ci;
        dither_en = 1'($urandom_range(1));
        nv = 0; ni = 0; nq = 0;
        pend_old = m_pend;
        if (rst) begin
            m_acc = 0; m_freq = 0; m_inv = 0; m_pend = 0; m_sh_freq = 0; m_sh_inv = 0;
        end else begin
            if (v) begin
                ph = clr ? 32'd0 : m_acc;
                th = int'(ph >> 20);
                c  = lo_val(th, 1);
                s  = lo_val(th, 0);
                if (m_inv) s = -s;
                ni = scale_sat(longint'(ii) * c - longint'(qq) * s);
                nq = scale_sat(longint'(ii) * s + longint'(qq) * c);
                nv = 1;
                m_acc = ph + m_freq;
                if (pend_old) begin
                    m_freq = m_sh_freq; m_inv = m_sh_inv; m_pend = 0;
                end
            end
            if (cv && !pend_old) begin
                m_sh_freq = cf; m_sh_inv = ci; m_pend = 1;
            end
        end
        @(posedge clk);
        if (rst) begin
            for (int k = 0; k < PIPE_LAT; k++) begin pv[k] = 0; pi[k] = 0; pq[k] = 0; end
            last_i = 0; last_q = 0;
        end else begin
            for (int k = PIPE_LAT - 1; k > 0; k--) begin
                pv[k] = pv[k-1]; pi[k] = pi[k-1]; pq[k] = pq[k-1];
            end
            pv[0] = nv; pi[0] = ni; pq[0] = nq;
            if (pv[PIPE_LAT-1]) begin last_i = pi[PIPE_LAT-1]; last_q = pq[PIPE_LAT-1]; end
        end
        @(negedge clk);
        chk("out_valid", out_valid, pv[PIPE_LAT-1]);
        chk("out_i", out_i, last_i);
        chk("out_q", out_q, last_q);
        chk("cfg_ready", cfg_ready, !m_pend);
    endtask

    task automatic sample(input int ii, input int qq, input bit clr);
        step(1, ii, qq, clr, 0, 0, 0, 0);
    endtask
    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(0, 0, 0, 0, 0, 0, 0, 0);
    endtask
    // Offer config on an idle cycle, then apply it with one throwaway sample.
    task automatic set_cfg(input logic [31:0] f, input bit ci);
        step(0, 0, 0, 0, 1, f, ci, 0);
        sample(0, 0, 0);
    endtask

    initial begin
        m_acc = 0; m_freq = 0; m_inv = 0; m_pend = 0; m_sh_freq = 0; m_sh_inv = 0;
        last_i = 0; last_q = 0;
        for (int k = 0; k < PIPE_LAT; k++) begin pv[k] = 0; pi[k] = 0; pq[k] = 0; end
        reset = 1; in_valid = 0; in_i = 0; in_q = 0; cfg_valid = 0; cfg_freq = 0;
        cfg_inv = 0; phase_clr = 0; dither_en = 0;
        @(negedge clk);
        step(0, 0, 0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 0, 0, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_i", out_i, 0);
        chk("rst_cfg_ready", cfg_ready, 1);

        // DC: freq 0 passes the input through
        sample(1000, 0, 1);
        for (int k = 0; k < 7; k++) sample(1000, 0, 0);
        idle(5);
        chk("dc_i", out_i, 1000);
        chk("dc_q", out_q, 0);

        // fs/4 rotation, then the conjugate
        set_cfg(32'h4000_0000, 0);
        sample(16384, 0, 1);
        for (int k = 0; k < 3; k++) sample(16384, 0, 0);
        idle(5);
        chk("fs4_i", out_i, 0);
        chk("fs4_q", out_q, -16383);
        set_cfg(32'h4000_0000, 1);
        sample(16384, 0, 1);
        for (int k = 0; k < 3; k++) sample(16384, 0, 0);
        idle(5);
        chk("fs4_inv_q", out_q, 16384);

        // pi/4 with full-scale input saturates out_q
        set_cfg(32'h2000_0000, 0);
        sample(32767, 32767, 1);
        sample(32767, 32767, 0);
        idle(5);
        chk("sat_i", out_i, 0);
        chk("sat_q", out_q, 32767);

        // Gapped input keeps 90 degree steps per accepted sample
        set_cfg(32'h4000_0000, 0);
        sample(12000, -5000, 1);
        idle(2);
        sample(12000, -5000, 0);
        idle(2);
        sample(12000, -5000, 0);
        sample(12000, -5000, 0);
        idle(6);

        // Config coincident with a sample: applied at the following sample
        step(1, 20000, 3000, 0, 1, 32'h1000_0000, 0, 0);
        chk("coinc_ready", cfg_ready, 0);
        idle(2);
        sample(20000, 3000, 0);
        for (int k = 0; k < 6; k++) sample(20000, 3000, 0);
        idle(5);

        // Reset with samples in flight
        sample(9000, 9000, 0);
        sample(9000, 9000, 0);
        sample(9000, 9000, 0);
        step(0, 0, 0, 0, 0, 0, 0, 1);
        idle(6);
        chk("flush_valid", out_valid, 0);
        chk("flush_i", out_i, 0);
        sample(7000, -7000, 0);
        idle(5);
        chk("post_rst_i", out_i, 7000);

        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            step(1'($urandom_range(3) != 0),
                 int'($urandom_range(65535)) - 32768,
                 int'($urandom_range(65535)) - 32768,
                 1'($urandom_range(31) == 0),
                 1'($urandom_range(7) == 0),
                 $urandom,
                 1'($urandom_range(1)),
                 0);
        end
        idle(6);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
